// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbitration of two writeback requesters onto
// the single register-file write port, with a registered write stage and a
// pending-write scoreboard used by issue logic to stall dependent reads.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [ADDR_W-1:0]         req0_addr,
  input  logic [DATA_W-1:0]         req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [ADDR_W-1:0]         req1_addr,
  input  logic [DATA_W-1:0]         req1_data,
  output logic                      req1_ready,
  input  logic                      mark_valid,
  input  logic [ADDR_W-1:0]         mark_addr,
  input  logic [ADDR_W-1:0]         q1_addr,
  input  logic [ADDR_W-1:0]         q2_addr,
  output logic                      stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         W1,
  output logic [DATA_W-1:0]         D1,
  output logic [(1<<ADDR_W)-1:0]    busy
);

  localparam int NREG = 1 << ADDR_W;

  // Register 0 is hardwired, so writes to it are dropped and it is never tracked.
  function automatic logic is_real_reg(input logic [ADDR_W-1:0] addr);
    return (addr != '0);
  endfunction

  logic                 last_grant;
  logic                 accept_p0;
  logic                 accept_sel_p0;
  logic [ADDR_W-1:0]    acc_addr_p0;
  logic [DATA_W-1:0]    acc_data_p0;
  logic                 wr_en_p1;
  logic [ADDR_W-1:0]    w1_p1;
  logic [DATA_W-1:0]    d1_p1;
  logic [NREG-1:0]      busy_q;
  logic [NREG-1:0]      busy_next;

  // Round-robin grant: a lone requester always wins, contention goes to the
  // requester that did not win last time.
  always_comb begin
    req0_ready = req0_valid & (~req1_valid | last_grant);
    req1_ready = req1_valid & (~req0_valid | ~last_grant);
  end

  // Select the accepted request for this cycle (stage p0).
  always_comb begin
    accept_p0     = req0_ready | req1_ready;
    accept_sel_p0 = req1_ready;
    acc_addr_p0   = req1_ready ? req1_addr : req0_addr;
    acc_data_p0   = req1_ready ? req1_data : req0_data;
  end

  // ---- stage p0 -> p1: register the winning write and the arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      wr_en_p1   <= 1'b0;
      w1_p1      <= '0;
      d1_p1      <= '0;
    end else begin
      if (accept_p0) begin
        last_grant <= accept_sel_p0;
      end
      if (accept_p0 && is_real_reg(acc_addr_p0)) begin
        wr_en_p1 <= 1'b1;
        w1_p1    <= acc_addr_p0;
        d1_p1    <= acc_data_p0;
      end else begin
        wr_en_p1 <= 1'b0;
        w1_p1    <= '0;
        d1_p1    <= '0;
      end
    end
  end

  assign wr_en = wr_en_p1;
  assign W1    = w1_p1;
  assign D1    = d1_p1;

  // Scoreboard next state: the write leaving p1 clears its register, a new
  // mark sets one; a mark wins over a clear of the same register.
  always_comb begin
    busy_next = busy_q;
    if (wr_en_p1) begin
      busy_next[w1_p1] = 1'b0;
    end
    if (mark_valid && is_real_reg(mark_addr)) begin
      busy_next[mark_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q[q1_addr] | busy_q[q2_addr];

endmodule
